// File: rtl/canvas_pkg.sv
// Shared types, colour constants and helpers
// for the canvas compositing core.
package canvas_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic        act;
    logic [10:0] ax;
    logic [10:0] ay;
  } pix_tag_t;

  localparam rgb_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb_t RGB_CROSS = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb_t RGB_TRACK = '{r: 8'h00, g: 8'h00, b: 8'hFF};
  localparam rgb_t RGB_LOST  = '{r: 8'hFF, g: 8'h7F, b: 8'h7F};
  localparam rgb_t RGB_HOT   = '{r: 8'h7F, g: 8'hFF, b: 8'h7F};

  function automatic int pix_width(input int cb);
    return 3 * cb;
  endfunction

  // p holds {r,g,b} at cb bits each, right-aligned
  function automatic rgb_t expand_rgb(
    input logic [23:0] p,
    input int          cb
  );
    logic [23:0] m;
    rgb_t        c;
    m   = (24'd1 << cb) - 24'd1;
    c.r = 8'(((p >> (2 * cb)) & m) << (8 - cb));
    c.g = 8'(((p >> cb) & m) << (8 - cb));
    c.b = 8'((p & m) << (8 - cb));
    return c;
  endfunction

  function automatic logic [10:0] abs_diff(
    input logic [10:0] a,
    input logic [10:0] b
  );
    return (a > b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/pos_divider.sv
// Sequential restoring divider, one quotient
// bit per cycle, start/done handshake.
module pos_divider #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CNT_W = $clog2(W + 1);

  logic [CNT_W-1:0] cnt;
  logic [W:0]       shifted;
  logic [W:0]       trial;

  assign shifted = {remainder, quotient[W-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy      <= 1'b1;
        cnt       <= CNT_W'(W);
        quotient  <= dividend;
        remainder <= '0;
      end else if (busy) begin
        if (!trial[W]) begin
          remainder <= trial[W-1:0];
          quotient  <= {quotient[W-2:0], 1'b1};
        end else begin
          remainder <= shifted[W-1:0];
          quotient  <= {quotient[W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/canvas_compositor.sv
// Paint/camera compositor: frame clear, write
// arbitration, VGA read pipeline, tracker.
module canvas_compositor
  import canvas_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int H_OFFSET     = 144,
  parameter int V_OFFSET     = 35,
  parameter int COLOR_BITS   = 3,
  parameter int ADDR_W       = 20,
  parameter int RADIUS_MIN   = 6,
  parameter int RADIUS_STEP  = 2,
  parameter int RADIUS_MAX   = 20,
  parameter int FILTER_SHIFT = 2,
  parameter int LOST_FRAMES  = 4,
  localparam int PIX_W = pix_width(COLOR_BITS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode,
  input  logic              color_sel,
  input  logic              clear_req,
  input  logic              radius_key,
  input  logic              vga_active,
  input  logic [10:0]       vga_x,
  input  logic [10:0]       vga_y,
  input  logic              vga_vsync,
  input  logic [PIX_W-1:0]  brush_rgb,
  input  logic              cursor_we,
  input  logic [ADDR_W-1:0] cursor_addr,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [7:0]        cam_pixel,
  input  logic [ADDR_W-1:0] det_pos,
  input  logic              det_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr_w,
  output logic [PIX_W-1:0]  mem_data_w,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr_r,
  input  logic [PIX_W-1:0]  mem_data_r,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic [5:0]        radius,
  output logic [10:0]       cursor_x,
  output logic [10:0]       cursor_y,
  output logic              tracking,
  output logic              busy
);

  localparam int FRAME = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FRAME - 1);
  localparam int MISS_W = $clog2(LOST_FRAMES + 1);

  state_t state;

  logic              run_we;
  logic [ADDR_W-1:0] run_addr;
  logic [PIX_W-1:0]  run_data;
  logic [PIX_W-1:0]  cam_ext;
  logic [6:0]        rad_sum;
  logic [5:0]        rad_next;

  always_comb begin
    cam_ext      = '0;
    cam_ext[7:0] = cam_pixel;
  end

  assign run_we   = mode ? cam_we : cursor_we;
  assign run_addr = mode ? cam_addr : cursor_addr;
  assign run_data = mode ? cam_ext : brush_rgb;

  assign rad_sum  = {1'b0, radius} + 7'(RADIUS_STEP);
  assign rad_next = (rad_sum > 7'(RADIUS_MAX)) ?
                    6'(RADIUS_MIN) : rad_sum[5:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_CLEAR;
      busy       <= 1'b1;
      mem_we     <= 1'b1;
      mem_addr_w <= '0;
      mem_data_w <= '0;
      radius     <= 6'(RADIUS_MIN);
    end else if (clear_req) begin
      state      <= ST_CLEAR;
      busy       <= 1'b1;
      mem_we     <= 1'b1;
      mem_addr_w <= '0;
      mem_data_w <= '0;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          if (mem_addr_w == LAST) begin
            state      <= ST_RUN;
            busy       <= 1'b0;
            mem_we     <= run_we;
            mem_addr_w <= run_addr;
            mem_data_w <= run_data;
          end else begin
            mem_addr_w <= mem_addr_w + 1'b1;
          end
        end
        ST_RUN: begin
          mem_we     <= run_we;
          mem_addr_w <= run_addr;
          mem_data_w <= run_data;
          if (radius_key && !mode && !color_sel) begin
            radius <= rad_next;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          mem_we     <= run_we;
          mem_addr_w <= run_addr;
          mem_data_w <= run_data;
          if (!radius_key) state <= ST_RUN;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Read path: address reg, RAM, output reg
  logic [10:0] ax0;
  logic [10:0] ay0;
  pix_tag_t    s1;
  pix_tag_t    s2;

  assign ax0 = vga_x - 11'(H_OFFSET + 1);
  assign ay0 = vga_y - 11'(V_OFFSET + 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1         <= '0;
      s2         <= '0;
      mem_re     <= 1'b0;
      mem_addr_r <= '0;
    end else begin
      s1         <= '{act: vga_active, ax: ax0, ay: ay0};
      s2         <= s1;
      mem_re     <= vga_active;
      mem_addr_r <= ADDR_W'(ay0) * ADDR_W'(H_ACTIVE)
                  + ADDR_W'(ax0);
    end
  end

  logic       on_cross;
  logic [7:0] gray;
  rgb_t       pix;

  assign on_cross =
    (s2.ax == cursor_x &&
     abs_diff(s2.ay, cursor_y) <= 11'(radius)) ||
    (s2.ay == cursor_y &&
     abs_diff(s2.ax, cursor_x) <= 11'(radius));

  assign gray = mem_data_r[7:0];

  always_comb begin
    pix = RGB_BLACK;
    if (busy || !s2.act) begin
      pix = RGB_BLACK;
    end else if (!mode) begin
      if (color_sel)
        pix = expand_rgb(24'(brush_rgb), COLOR_BITS);
      else if (on_cross)
        pix = RGB_CROSS;
      else
        pix = expand_rgb(24'(mem_data_r), COLOR_BITS);
    end else if (tracking &&
                 (s2.ax == cursor_x || s2.ay == cursor_y)) begin
      pix = RGB_TRACK;
    end else if (!tracking &&
                 s2.ay == 11'(V_ACTIVE / 2)) begin
      pix = RGB_LOST;
    end else if (gray > 8'd127) begin
      pix = RGB_HOT;
    end else begin
      pix = '{r: {gray[6:0], 1'b0},
              g: {gray[6:0], 1'b0},
              b: {gray[6:0], 1'b0}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      vga_r <= pix.r;
      vga_g <= pix.g;
      vga_b <= pix.b;
    end
  end

  // Finger tracker, one sample per frame
  logic              vsync_d;
  logic              rise;
  logic              hit;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [ADDR_W-1:0] div_q;
  logic [ADDR_W-1:0] div_r;
  logic [MISS_W-1:0] miss_cnt;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [11:0] step_x;
  logic signed [11:0] step_y;
  logic              unused_bits;

  assign rise = vga_vsync && !vsync_d;
  assign hit  = det_valid &&
                (det_pos < ADDR_W'(FRAME));
  assign div_start = rise && hit && !div_busy;

  assign dx = $signed({1'b0, div_r[10:0]})
            - $signed({1'b0, cursor_x});
  assign dy = $signed({1'b0, div_q[10:0]})
            - $signed({1'b0, cursor_y});
  assign step_x = dx >>> FILTER_SHIFT;
  assign step_y = dy >>> FILTER_SHIFT;

  assign unused_bits = ^{div_q[ADDR_W-1:11],
                         div_r[ADDR_W-1:11],
                         step_x[11], step_y[11]};

  pos_divider #(
    .W (ADDR_W)
  ) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .dividend  (det_pos),
    .divisor   (ADDR_W'(H_ACTIVE)),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_d  <= 1'b0;
      miss_cnt <= '0;
      tracking <= 1'b0;
      cursor_x <= '0;
      cursor_y <= '0;
    end else begin
      vsync_d <= vga_vsync;
      if (rise && !div_busy) begin
        if (hit) begin
          miss_cnt <= '0;
        end else begin
          if (miss_cnt == MISS_W'(LOST_FRAMES - 1))
            tracking <= 1'b0;
          if (miss_cnt != MISS_W'(LOST_FRAMES))
            miss_cnt <= miss_cnt + 1'b1;
        end
      end
      if (div_done) begin
        if (!tracking) begin
          tracking <= 1'b1;
          cursor_x <= div_r[10:0];
          cursor_y <= div_q[10:0];
        end else begin
          cursor_x <= cursor_x + step_x[10:0];
          cursor_y <= cursor_y + step_y[10:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_canvas_compositor.sv
// Directed bench for canvas_compositor on a
// reduced 16x8 frame with a behavioural RAM.
module tb_canvas_compositor;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int HO = 144;
  localparam int VO = 35;
  localparam int AW = 20;
  localparam int N  = H * V;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mode = 1'b0;
  logic          color_sel = 1'b0;
  logic          clear_req = 1'b0;
  logic          radius_key = 1'b0;
  logic          vga_active = 1'b0;
  logic [10:0]   vga_x = '0;
  logic [10:0]   vga_y = '0;
  logic          vga_vsync = 1'b0;
  logic [8:0]    brush_rgb = '0;
  logic          cursor_we = 1'b0;
  logic [AW-1:0] cursor_addr = '0;
  logic          cam_we = 1'b0;
  logic [AW-1:0] cam_addr = '0;
  logic [7:0]    cam_pixel = '0;
  logic [AW-1:0] det_pos = '0;
  logic          det_valid = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr_w;
  logic [8:0]    mem_data_w;
  logic          mem_re;
  logic [AW-1:0] mem_addr_r;
  logic [8:0]    mem_data_r = '0;
  logic [7:0]    vga_r;
  logic [7:0]    vga_g;
  logic [7:0]    vga_b;
  logic [5:0]    radius;
  logic [10:0]   cursor_x;
  logic [10:0]   cursor_y;
  logic          tracking;
  logic          busy;

  int vec_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;

  canvas_compositor #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .H_OFFSET   (HO),
    .V_OFFSET   (VO),
    .COLOR_BITS (3),
    .ADDR_W     (AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .color_sel   (color_sel),
    .clear_req   (clear_req),
    .radius_key  (radius_key),
    .vga_active  (vga_active),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_vsync   (vga_vsync),
    .brush_rgb   (brush_rgb),
    .cursor_we   (cursor_we),
    .cursor_addr (cursor_addr),
    .cam_we      (cam_we),
    .cam_addr    (cam_addr),
    .cam_pixel   (cam_pixel),
    .det_pos     (det_pos),
    .det_valid   (det_valid),
    .mem_we      (mem_we),
    .mem_addr_w  (mem_addr_w),
    .mem_data_w  (mem_data_w),
    .mem_re      (mem_re),
    .mem_addr_r  (mem_addr_r),
    .mem_data_r  (mem_data_r),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .radius      (radius),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .tracking    (tracking),
    .busy        (busy)
  );

  logic [8:0] ram [0:N-1];

  always @(posedge clk) begin
    if (mem_we && mem_addr_w < AW'(N))
      ram[mem_addr_w[6:0]] <= mem_data_w;
    if (mem_addr_r < AW'(N))
      mem_data_r <= ram[mem_addr_r[6:0]];
    else
      mem_data_r <= '0;
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    vec_n++;
    if (got !== want) begin
      err_n++;
      $display("FAIL %s: got %0h want %0h",
               nm, got, want);
    end
  endtask

  task automatic sweep(input string nm);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int i = 0; i < N; i++) begin
      if (busy !== 1'b1 || mem_we !== 1'b1 ||
          mem_addr_w !== AW'(i) ||
          mem_data_w !== 9'd0 ||
          {vga_r, vga_g, vga_b} !== 24'd0) begin
        bad++;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
    chk({nm, "_bad_cycles"}, 32'(bad), 32'd0);
    if (bad != 0)
      $display("FAIL %s: first bad at %0d",
               nm, first);
    chk({nm, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic probe(input int x, input int y,
                       input logic act,
                       output logic [23:0] rgb);
    vga_x = 11'(x + HO + 1);
    vga_y = 11'(y + VO + 1);
    vga_active = act;
    repeat (3) @(negedge clk);
    vga_active = 1'b0;
    rgb = {vga_r, vga_g, vga_b};
  endtask

  task automatic frame(input logic v,
                       input logic [AW-1:0] p);
    det_valid = v;
    det_pos = p;
    vga_vsync = 1'b1;
    @(negedge clk);
    vga_vsync = 1'b0;
    repeat (AW + 4) @(negedge clk);
  endtask

  task automatic key_pulse;
    radius_key = 1'b1;
    repeat (2) @(negedge clk);
    radius_key = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic        mode;
    logic        csel;
    logic [8:0]  brush;
    logic [7:0]  cam;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_t;

  vec_t       tv [13];
  int         rexp [8];
  logic [23:0] got;

  initial begin
    tv[0]  = '{1'b0, 1'b0, 9'o700, 8'd0, 10, 5, 24'hE00000};
    tv[1]  = '{1'b0, 1'b0, 9'o070, 8'd0, 12, 6, 24'h00E000};
    tv[2]  = '{1'b0, 1'b0, 9'o523, 8'd0, 9, 3, 24'hA04060};
    tv[3]  = '{1'b0, 1'b1, 9'o147, 8'd0, 11, 2, 24'h2080E0};
    tv[4]  = '{1'b0, 1'b0, 9'o007, 8'd0, 0, 6, 24'hFF0000};
    tv[5]  = '{1'b0, 1'b0, 9'o007, 8'd0, 7, 0, 24'h0000E0};
    tv[6]  = '{1'b0, 1'b0, 9'o200, 8'd0, 0, 7, 24'h400000};
    tv[7]  = '{1'b1, 1'b0, 9'o000, 8'd200, 3, 2, 24'h7FFF7F};
    tv[8]  = '{1'b1, 1'b0, 9'o000, 8'd60, 5, 1, 24'h787878};
    tv[9]  = '{1'b1, 1'b0, 9'o000, 8'd127, 6, 6, 24'hFEFEFE};
    tv[10] = '{1'b1, 1'b0, 9'o000, 8'd128, 2, 5, 24'h7FFF7F};
    tv[11] = '{1'b1, 1'b0, 9'o000, 8'd10, 8, 4, 24'hFF7F7F};
    tv[12] = '{1'b1, 1'b0, 9'o000, 8'd1, 0, 0, 24'h020202};
    rexp = '{8, 10, 12, 14, 16, 18, 20, 6};

    repeat (3) @(negedge clk);
    chk("rst_radius", 32'(radius), 32'd6);
    chk("rst_busy_we", {30'd0, busy, mem_we}, 32'd3);
    chk("rst_vga", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("rst_track",
        {9'd0, tracking, cursor_x, cursor_y}, 32'd0);
    chk("rst_re", {31'd0, mem_re}, 32'd0);

    reset_n = 1'b1;
    sweep("clear0");

    mode = 1'b0;
    brush_rgb = 9'o700;
    cursor_addr = AW'(1000);
    cursor_we = 1'b1;
    @(negedge clk);
    cursor_we = 1'b0;
    chk("wr_cursor_we", {31'd0, mem_we}, 32'd1);
    chk("wr_cursor_addr", 32'(mem_addr_w), 32'd1000);
    chk("wr_cursor_data", 32'(mem_data_w), 32'h1C0);
    @(negedge clk);
    chk("wr_idle_we", {31'd0, mem_we}, 32'd0);
    mode = 1'b1;
    cam_addr = AW'(77);
    cam_pixel = 8'hAB;
    cam_we = 1'b1;
    cursor_we = 1'b1;
    @(negedge clk);
    cam_we = 1'b0;
    cursor_we = 1'b0;
    chk("wr_cam_addr", 32'(mem_addr_w), 32'd77);
    chk("wr_cam_data", 32'(mem_data_w), 32'h0AB);

    for (int i = 0; i < 13; i++) begin
      mode = tv[i].mode;
      brush_rgb = tv[i].brush;
      cam_pixel = tv[i].cam;
      cursor_addr = AW'(tv[i].y * H + tv[i].x);
      cam_addr = cursor_addr;
      cursor_we = !tv[i].mode;
      cam_we = tv[i].mode;
      @(negedge clk);
      cursor_we = 1'b0;
      cam_we = 1'b0;
      repeat (2) @(negedge clk);
      color_sel = tv[i].csel;
      probe(tv[i].x, tv[i].y, 1'b1, got);
      color_sel = 1'b0;
      chk($sformatf("vec%0d_rgb", i), 32'(got),
          32'(tv[i].rgb));
    end

    mode = 1'b0;
    vga_x = 11'(9 + HO + 1);
    vga_y = 11'(3 + VO + 1);
    vga_active = 1'b1;
    @(negedge clk);
    vga_active = 1'b0;
    chk("rd_addr", 32'(mem_addr_r), 32'(3 * H + 9));
    chk("rd_re", {31'd0, mem_re}, 32'd1);
    probe(10, 5, 1'b0, got);
    chk("inactive_rgb", 32'(got), 32'd0);

    for (int i = 0; i < 8; i++) begin
      key_pulse();
      chk($sformatf("radius_p%0d", i),
          32'(radius), 32'(rexp[i]));
    end
    radius_key = 1'b1;
    repeat (5) @(negedge clk);
    radius_key = 1'b0;
    repeat (2) @(negedge clk);
    chk("radius_held", 32'(radius), 32'd8);
    color_sel = 1'b1;
    key_pulse();
    color_sel = 1'b0;
    chk("radius_csel", 32'(radius), 32'd8);
    mode = 1'b1;
    key_pulse();
    mode = 1'b0;
    chk("radius_mode1", 32'(radius), 32'd8);

    frame(1'b1, AW'(H * 5 + 4));
    chk("trk_first", {20'd0, tracking, cursor_x[4:0],
        cursor_y[5:0]}, {20'd0, 1'b1, 5'd4, 6'd5});
    frame(1'b1, AW'(H * 5 + 12));
    chk("trk_ema_up", 32'(cursor_x), 32'd6);
    chk("trk_ema_y", 32'(cursor_y), 32'd5);
    frame(1'b1, AW'(H * 5));
    chk("trk_ema_dn", 32'(cursor_x), 32'd4);

    mode = 1'b1;
    probe(4, 2, 1'b1, got);
    chk("blue_col", 32'(got), 32'h0000FF);
    probe(9, 5, 1'b1, got);
    chk("blue_row", 32'(got), 32'h0000FF);
    probe(9, 3, 1'b1, got);
    chk("gray_trk", 32'(got), 32'hA6A6A6);
    probe(8, 4, 1'b1, got);
    chk("no_lost_row", 32'(got), 32'h141414);
    mode = 1'b0;
    probe(4, 0, 1'b1, got);
    chk("cross_trk", 32'(got), 32'hFF0000);

    frame(1'b1, AW'(N + 72));
    frame(1'b0, AW'(H * 5 + 4));
    frame(1'b0, '0);
    chk("trk_miss3", {31'd0, tracking}, 32'd1);
    frame(1'b0, '0);
    chk("trk_lost", {31'd0, tracking}, 32'd0);
    chk("trk_hold", {21'd0, cursor_x[4:0],
        cursor_y[5:0]}, {21'd0, 5'd4, 6'd5});
    mode = 1'b1;
    probe(3, 4, 1'b1, got);
    chk("lost_row", 32'(got), 32'hFF7F7F);
    mode = 1'b0;

    det_valid = 1'b1;
    det_pos = AW'(H * 6 + 4);
    vga_vsync = 1'b1;
    @(negedge clk);
    vga_vsync = 1'b0;
    det_pos = AW'(H * 7 + 4);
    repeat (2) @(negedge clk);
    vga_vsync = 1'b1;
    @(negedge clk);
    vga_vsync = 1'b0;
    repeat (AW + 4) @(negedge clk);
    chk("busy_ignore", {20'd0, tracking, cursor_x[4:0],
        cursor_y[5:0]}, {20'd0, 1'b1, 5'd4, 6'd6});

    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    sweep("clear_run");
    repeat (3) @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_clear_addr", 32'(mem_addr_w), 32'd50);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    sweep("clear_mid");

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, err_n);
    $finish;
  end

endmodule
